// File: rtl/shift_lr_pipe_pkg.sv
// Shared opcode constants and helpers for the Mosaic FU shifter.
package shift_lr_pipe_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_SLL = 3'b000;
  localparam op_t OP_SRL = 3'b001;
  localparam op_t OP_SRA = 3'b010;
  localparam op_t OP_ROL = 3'b011;
  localparam op_t OP_ROR = 3'b100;

  // Left shifts and rotates are mapped onto the right funnel with a negated amount.
  function automatic logic op_is_left(input op_t op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_lr_funnel_stage.sv
// One mux level of the right funnel. The STEP top bits of the shifted word can
// never reach the final W-bit result, so each level drops them.
module shift_lr_funnel_stage #(
  parameter int IN_W = 63,
  parameter int STEP = 1
) (
  input  logic [IN_W-1:0]      i_d,
  input  logic                 i_sel,
  output logic [IN_W-STEP-1:0] o_d
);

  // Either shift right by STEP or pass through, both truncated to the output width.
  assign o_d = i_sel ? i_d[IN_W-1:STEP] : i_d[IN_W-STEP-1:0];

endmodule

// File: rtl/shift_lr_pipe.sv
// Pipelined bi-directional shifter/rotator with valid/ready flow control.
// S0 holds operands, S1 sits after the upper amount-bit mux levels, S2 holds
// the result and flags. Every op is built as a right funnel of {hi, lo} by r.
module shift_lr_pipe
  import shift_lr_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 4,
  localparam int SW   = $clog2(W)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [SW-1:0]    in_s,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_err
);

  localparam int N_LO = SW / 2;
  localparam int N_HI = SW - N_LO;
  // Word width after the upper levels: W plus the largest shift still to come.
  localparam int S1_W = W + (1 << N_LO) - 1;

  logic r_v0, r_v1, r_v2;
  logic w_load0, w_load1, w_load2;

  logic [W-1:0]     r_s0_x;
  logic [SW-1:0]    r_s0_s;
  op_t              r_s0_op;
  logic [TAG_W-1:0] r_s0_tag;

  logic [2*W-2:0]   w_word;
  logic [SW-1:0]    w_r;
  logic             w_err;

  logic [S1_W-1:0]  r_s1_word;
  logic [N_LO-1:0]  r_s1_r;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_err;

  logic [W-1:0]     w_z;

  logic [W-1:0]     r_out_z;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_zero;
  logic             r_out_err;

  // Valid chain: a stage loads when empty or when the next stage loads.
  assign w_load2  = !r_v2 || out_ready;
  assign w_load1  = !r_v1 || w_load2;
  assign w_load0  = !r_v0 || w_load1;
  assign in_ready = w_load0;
  assign out_valid = r_v2;

  // Stage valid bits; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_load0) r_v0 <= in_valid;
      if (w_load1) r_v1 <= r_v0;
      if (w_load2) r_v2 <= r_v1;
    end
  end

  // S0 operand capture on input transfer.
  always_ff @(posedge clock) begin
    if (w_load0 && in_valid) begin
      r_s0_x   <= in_x;
      r_s0_s   <= in_s;
      r_s0_op  <= in_op;
      r_s0_tag <= in_tag;
    end
  end

  // Funnel setup. hi[W-1] is never selected for r < W, so the word is 2W-1 bits.
  // With s == 0 the amount is 0 and lo is x for every op, giving x exactly.
  always_comb begin
    w_word = {{(W-1){1'b0}}, r_s0_x};
    w_r    = op_is_left(r_s0_op) ? (SW'(0) - r_s0_s) : r_s0_s;
    w_err  = 1'b0;
    case (r_s0_op)
      OP_SLL:  w_word = (r_s0_s == '0) ? {r_s0_x[W-2:0], r_s0_x}
                                       : {r_s0_x[W-2:0], {W{1'b0}}};
      OP_SRL:  w_word = {{(W-1){1'b0}}, r_s0_x};
      OP_SRA:  w_word = {{(W-1){r_s0_x[W-1]}}, r_s0_x};
      OP_ROL:  w_word = {r_s0_x[W-2:0], r_s0_x};
      OP_ROR:  w_word = {r_s0_x[W-2:0], r_s0_x};
      default: begin
        w_r   = '0;
        w_err = 1'b1;
      end
    endcase
  end

  for (genvar i = 0; i < N_HI; i++) begin : g_hi
    localparam int K  = SW - 1 - i;
    localparam int IW = W + (1 << (K + 1)) - 1;
    logic [IW-1:0]          w_in;
    logic [IW-(1<<K)-1:0]   w_out;
    if (i == 0) begin : g_first
      assign w_in = w_word;
    end else begin : g_next
      assign w_in = g_hi[i-1].w_out;
    end
    shift_lr_funnel_stage #(.IN_W(IW), .STEP(1 << K)) u_stage (
      .i_d   (w_in),
      .i_sel (w_r[K]),
      .o_d   (w_out)
    );
  end

  // S1 capture of the partially shifted word and the remaining amount bits.
  always_ff @(posedge clock) begin
    if (w_load1 && r_v0) begin
      r_s1_word <= g_hi[N_HI-1].w_out;
      r_s1_r    <= w_r[N_LO-1:0];
      r_s1_tag  <= r_s0_tag;
      r_s1_err  <= w_err;
    end
  end

  for (genvar i = 0; i < N_LO; i++) begin : g_lo
    localparam int K  = N_LO - 1 - i;
    localparam int IW = W + (1 << (K + 1)) - 1;
    logic [IW-1:0]          w_in;
    logic [IW-(1<<K)-1:0]   w_out;
    if (i == 0) begin : g_first
      assign w_in = r_s1_word;
    end else begin : g_next
      assign w_in = g_lo[i-1].w_out;
    end
    shift_lr_funnel_stage #(.IN_W(IW), .STEP(1 << K)) u_stage (
      .i_d   (w_in),
      .i_sel (r_s1_r[K]),
      .o_d   (w_out)
    );
  end

  assign w_z = g_lo[N_LO-1].w_out;

  // S2 result and flags; held while the consumer stalls.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out_z    <= '0;
      r_out_tag  <= '0;
      r_out_zero <= 1'b0;
      r_out_err  <= 1'b0;
    end else if (w_load2 && r_v1) begin
      r_out_z    <= w_z;
      r_out_tag  <= r_s1_tag;
      r_out_zero <= (w_z == '0);
      r_out_err  <= r_s1_err;
    end
  end

  assign out_z    = r_out_z;
  assign out_tag  = r_out_tag;
  assign out_zero = r_out_zero;
  assign out_err  = r_out_err;

endmodule

// File: tb/tb_shift_lr_pipe.sv
// Scoreboard bench for shift_lr_pipe (W=32, TAG_W=4).
module tb_shift_lr_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [4:0]  in_s;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_err;

  shift_lr_pipe #(.W(32), .TAG_W(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_s      (in_s),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  tag;
    logic        zero;
    logic        err;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_miscompare = 0;
  int   cyc = 0;

  logic        use_lit = 1'b0;
  logic [31:0] lit_z;
  logic        lit_err;
  logic        stream_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] x, input int s);
    case (op)
      3'd0:    return x << s;
      3'd1:    return x >> s;
      3'd2:    return 32'($signed(x) >>> s);
      3'd3:    return (x << s) | (x >> (32 - s));
      3'd4:    return (x >> s) | (x << (32 - s));
      default: return x;
    endcase
  endfunction

  // Monitor and scoreboard: capacity-3 pipeline, head emerges 3 cycles after accept.
  always @(negedge clock) begin
    exp_t e;
    logic exp_ov;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      check("in_ready", 64'(in_ready), 64'((exp_q.size() < 3) || out_ready));
      exp_ov = 1'b0;
      if (exp_q.size() > 0) exp_ov = (cyc - exp_q[0].acc) >= 3;
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_miscompare++;
          $display("FAIL spurious_output: got tag 0x%0h expected no output (cycle %0d)", out_tag, cyc);
        end else begin
          e = exp_q[0];
          check("out_z",    64'(out_z),    64'(e.z));
          check("out_tag",  64'(out_tag),  64'(e.tag));
          check("out_zero", 64'(out_zero), 64'(e.zero));
          check("out_err",  64'(out_err),  64'(e.err));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e.z    = use_lit ? lit_z : ref_shift(in_op, in_x, int'(in_s));
        e.err  = use_lit ? lit_err : (in_op > 3'd4);
        e.zero = (e.z == 32'd0);
        e.tag  = in_tag;
        e.acc  = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [4:0] s, input logic [3:0] tag);
    int guard = 0;
    in_valid = 1'b1;
    in_op = op;
    in_x = x;
    in_s = s;
    in_tag = tag;
    @(negedge clock);
    while (!in_ready) begin
      guard++;
      if (guard > 300) begin
        n_checks++;
        n_miscompare++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 within 300 cycles (tag 0x%0h)", tag);
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    use_lit = 1'b0;
  endtask

  task automatic send_lit(input logic [2:0] op, input logic [31:0] x, input logic [4:0] s,
                          input logic [3:0] tag, input logic [31:0] z, input logic err);
    use_lit = 1'b1;
    lit_z = z;
    lit_err = err;
    send(op, x, s, tag);
  endtask

  task automatic send_rand(input logic [3:0] tag);
    logic [31:0] x;
    x = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
    send(3'($urandom_range(0, 7)), x, 5'($urandom_range(0, 31)), tag);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clock);
      #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_miscompare++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_s = '0;
    in_op = '0;
    in_tag = '0;
    out_ready = 1'b1;
    stream_done = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_z",     64'(out_z),     64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_out_zero",  64'(out_zero),  64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    @(posedge clock);
    #1;

    // Directed values
    send_lit(3'd0, 32'h8000_0001, 5'd1, 4'd3, 32'h0000_0002, 1'b0);
    drain();
    send_lit(3'd2, 32'h8000_0000, 5'd31, 4'd1, 32'hFFFF_FFFF, 1'b0);
    send_lit(3'd1, 32'h8000_0000, 5'd31, 4'd2, 32'h0000_0001, 1'b0);
    send_lit(3'd3, 32'h8000_0001, 5'd4,  4'd4, 32'h0000_0018, 1'b0);
    send_lit(3'd4, 32'h0000_0001, 5'd1,  4'd5, 32'h8000_0000, 1'b0);
    for (int op = 0; op < 5; op++)
      send_lit(3'(op), 32'hDEAD_BEEF, 5'd0, 4'(op + 6), 32'hDEAD_BEEF, 1'b0);
    send_lit(3'b110, 32'hDEAD_BEEF, 5'd0, 4'd11, 32'hDEAD_BEEF, 1'b1);
    send_lit(3'b111, 32'h1234_5678, 5'd9, 4'd12, 32'h1234_5678, 1'b1);
    drain();

    // Backpressure stream, tags 0..9
    fork
      begin
        for (int t = 0; t < 10; t++) send_rand(4'(t));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          if (c < 5)       out_ready = 1'b1;
          else if (c < 10) out_ready = 1'b0;
          else             out_ready = 1'($urandom_range(0, 1));
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random gaps and stalls
    stream_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clock);
            #1;
          end
          send_rand(4'($urandom_range(0, 15)));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight
    out_ready = 1'b0;
    send_rand(4'd1);
    send_rand(4'd2);
    send_rand(4'd3);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_z",     64'(out_z),     64'd0);
    repeat (10) @(posedge clock);
    #1;
    send_lit(3'd1, 32'h0000_0000, 5'd5, 4'd7, 32'h0000_0000, 1'b0);
    drain();
    repeat (3) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompare);
    $finish;
  end

endmodule
